// File: rtl/load_window_k.sv
// KxK activation window loader: reads a runtime-sized byte window from two BRAM read ports
// (even rows on port 0, odd rows on port 1), with an optional shift-left/new-column mode.
module load_window_k #(
  parameter int DATA_WIDTH    = 8,
  parameter int KMAX          = 5,
  parameter int BRAM_ADDR_BIT = 32,
  parameter int BRAM_WIDTH    = 32,
  parameter int RD_LAT        = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               shift,
  input  logic [2:0]                         ksize,
  input  logic [BRAM_ADDR_BIT-1:0]           base_addr,
  input  logic [15:0]                        row_pitch,
  output logic [KMAX*KMAX*DATA_WIDTH-1:0]    window,
  output logic                               done,
  output logic                               busy,
  output logic                               err,
  output logic                               BRAM_clk,
  output logic                               BRAM_en,
  output logic                               BRAM_rst,
  output logic [BRAM_WIDTH-1:0]              BRAM_din,
  output logic [BRAM_WIDTH/8-1:0]            BRAM_wen,
  output logic [BRAM_ADDR_BIT-1:0]           BRAM_0_addr,
  output logic [BRAM_ADDR_BIT-1:0]           BRAM_1_addr,
  input  logic [BRAM_WIDTH-1:0]              BRAM_0_dout,
  input  logic [BRAM_WIDTH-1:0]              BRAM_1_dout
);

  localparam int LANES = BRAM_WIDTH / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IW    = $clog2(KMAX + 1);
  localparam int NE    = KMAX * KMAX;
  localparam int NW    = $clog2(NE);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic [LW-1:0] lane;
  } tag_t;

  typedef struct packed {
    logic first;
    tag_t p0;
    tag_t p1;
  } stage_t;

  logic [1:0]               state_q;
  logic [IW-1:0]            k_q, col_q, pair_q;
  logic                     shift_q, err_q;
  logic [BRAM_ADDR_BIT-1:0] row_base_q, pitch_q;
  logic [1:0]               drain_q;
  stage_t                   pipe_q [RD_LAT];
  logic [DATA_WIDTH-1:0]    win_q  [NE];
  logic [DATA_WIDTH-1:0]    win_d  [NE];

  logic [IW-1:0]            last_k, col_start, row0, row1;
  logic [IW:0]              npairs;
  logic                     issuing, last_pair, p1_valid, bad_k;
  logic [BRAM_ADDR_BIT-1:0] addr0, addr1;
  stage_t                   tag_in, cap;

  function automatic logic [DATA_WIDTH-1:0] pick(input logic [BRAM_WIDTH-1:0] d,
                                                 input logic [LW-1:0] lane);
    logic [BRAM_WIDTH-1:0] s;
    s = d >> {lane, 3'b000};
    return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [NW-1:0] idx(input logic [IW-1:0] r, input logic [IW-1:0] c);
    return NW'(int'(r) * KMAX + int'(c));
  endfunction

  always_comb begin
    last_k    = k_q - 1'b1;
    col_start = shift_q ? last_k : '0;
    npairs    = ({1'b0, k_q} + 1'b1) >> 1;
    last_pair = ({1'b0, pair_q} == npairs - 1'b1);
    row0      = IW'({pair_q, 1'b0});
    row1      = row0 + 1'b1;
    p1_valid  = row1 < k_q;
    issuing   = (state_q == StIssue);
    addr0     = row_base_q + BRAM_ADDR_BIT'(col_q);
    addr1     = row_base_q + pitch_q + BRAM_ADDR_BIT'(col_q);
    bad_k     = (ksize == 3'd0) || (int'(ksize) > KMAX);
    tag_in    = '{first: issuing && (pair_q == '0) && (col_q == col_start),
                  p0: '{v: issuing, row: row0, col: col_q, lane: addr0[LW-1:0]},
                  p1: '{v: issuing && p1_valid, row: row1, col: col_q, lane: addr1[LW-1:0]}};
    cap       = pipe_q[RD_LAT-1];
  end

  // Shift/clear happens on the first capture edge so the window holds until data returns.
  always_comb begin
    win_d = win_q;
    if (cap.first) begin
      if (shift_q) begin
        for (int r = 0; r < KMAX; r++) begin
          for (int c = 0; c < KMAX - 1; c++) begin
            if (r < int'(k_q) && c + 1 < int'(k_q)) win_d[r*KMAX+c] = win_q[r*KMAX+c+1];
          end
        end
      end else begin
        for (int r = 0; r < KMAX; r++) begin
          for (int c = 0; c < KMAX; c++) begin
            if (r >= int'(k_q) || c >= int'(k_q)) win_d[r*KMAX+c] = '0;
          end
        end
      end
    end
    if (cap.p0.v) win_d[idx(cap.p0.row, cap.p0.col)] = pick(BRAM_0_dout, cap.p0.lane);
    if (cap.p1.v) win_d[idx(cap.p1.row, cap.p1.col)] = pick(BRAM_1_dout, cap.p1.lane);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      col_q      <= '0;
      pair_q     <= '0;
      shift_q    <= 1'b0;
      err_q      <= 1'b0;
      row_base_q <= '0;
      pitch_q    <= '0;
      drain_q    <= '0;
      pipe_q     <= '{default: '0};
      win_q      <= '{default: '0};
    end else begin
      err_q <= 1'b0;
      pipe_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      win_q <= win_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (bad_k) begin
              err_q <= 1'b1;
            end else begin
              k_q        <= IW'(ksize);
              shift_q    <= shift;
              pitch_q    <= BRAM_ADDR_BIT'(row_pitch);
              row_base_q <= base_addr;
              col_q      <= shift ? IW'(ksize) - 1'b1 : '0;
              pair_q     <= '0;
              state_q    <= StIssue;
            end
          end
        end
        StIssue: begin
          if (col_q == last_k) begin
            col_q      <= col_start;
            pair_q     <= pair_q + 1'b1;
            row_base_q <= row_base_q + (pitch_q << 1);
            if (last_pair) begin
              drain_q <= '0;
              state_q <= StDrain;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        StDrain: begin
          if (drain_q == 2'(RD_LAT - 1)) state_q <= StDone;
          else drain_q <= drain_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < NE; i++) window[i*DATA_WIDTH +: DATA_WIDTH] = win_q[i];
  end

  assign done        = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign err         = err_q;
  assign BRAM_0_addr = issuing ? addr0 : '0;
  assign BRAM_1_addr = (issuing && p1_valid) ? addr1 : '0;
  assign BRAM_clk    = clk;
  assign BRAM_en     = 1'b1;
  assign BRAM_rst    = 1'b0;
  assign BRAM_din    = '0;
  assign BRAM_wen    = '0;

endmodule

// File: tb/tb_load_window_k.sv
// Directed bench for load_window_k: byte-addressed BRAM models (RD_LAT 1 and 2), per-cycle
// address checks, done timing, window contents, rejection, start-while-busy and mid-op reset.
module tb_load_window_k;
  localparam int KM = 5;
  localparam int WW = KM * KM * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2, shift;
  logic [2:0]  ksize;
  logic [31:0] base_addr;
  logic [15:0] row_pitch;

  logic [WW-1:0] win1, win2;
  logic done1, busy1, err1, bclk1, ben1, brst1, done2, busy2, err2, bclk2, ben2, brst2;
  logic [31:0] bdin1, bdin2, a0_1, a1_1, a0_2, a1_2, d0_1, d1_1, d0_2, d1_2, p0_2, p1_2;
  logic [3:0]  bwen1, bwen2;

  load_window_k #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .ksize(ksize),
    .base_addr(base_addr), .row_pitch(row_pitch), .window(win1), .done(done1), .busy(busy1),
    .err(err1), .BRAM_clk(bclk1), .BRAM_en(ben1), .BRAM_rst(brst1), .BRAM_din(bdin1),
    .BRAM_wen(bwen1), .BRAM_0_addr(a0_1), .BRAM_1_addr(a1_1),
    .BRAM_0_dout(d0_1), .BRAM_1_dout(d1_1)
  );

  load_window_k #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .shift(shift), .ksize(ksize),
    .base_addr(base_addr), .row_pitch(row_pitch), .window(win2), .done(done2), .busy(busy2),
    .err(err2), .BRAM_clk(bclk2), .BRAM_en(ben2), .BRAM_rst(brst2), .BRAM_din(bdin2),
    .BRAM_wen(bwen2), .BRAM_0_addr(a0_2), .BRAM_1_addr(a1_2),
    .BRAM_0_dout(d0_2), .BRAM_1_dout(d1_2)
  );

  // Byte at address a holds a[7:0]; each word returns its four aligned bytes.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    return {w[7:0] + 8'd3, w[7:0] + 8'd2, w[7:0] + 8'd1, w[7:0]};
  endfunction

  always @(posedge clk) begin
    d0_1 <= mem_word(a0_1);
    d1_1 <= mem_word(a1_1);
    p0_2 <= mem_word(a0_2);
    p1_2 <= mem_word(a1_2);
    d0_2 <= p0_2;
    d1_2 <= p1_2;
  end

  int sel = 0;
  logic [WW-1:0] o_win;
  logic          o_done, o_busy, o_err;
  logic [31:0]   o_a0, o_a1;
  assign o_win  = (sel == 0) ? win1  : win2;
  assign o_done = (sel == 0) ? done1 : done2;
  assign o_busy = (sel == 0) ? busy1 : busy2;
  assign o_err  = (sel == 0) ? err1  : err2;
  assign o_a0   = (sel == 0) ? a0_1  : a0_2;
  assign o_a1   = (sel == 0) ? a1_1  : a1_2;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_win [KM*KM];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] pack_exp();
    logic [WW-1:0] v;
    for (int i = 0; i < KM * KM; i++) v[i*8 +: 8] = exp_win[i];
    return v;
  endfunction

  task automatic run_load(input int dsel, input int k, input bit sh, input logic [31:0] base,
                          input logic [15:0] pitch, input int exp_done, input int restart,
                          input string tag);
    int nc, n, done_cyc, p, c, r1, j;
    bit busy_ok, err_seen;
    logic [31:0] e0, e1;
    nc = sh ? 1 : k;
    n  = ((k + 1) / 2) * nc;
    for (int r = 0; r < KM; r++) begin
      for (int cc = 0; cc < KM; cc++) begin
        if (sh) begin
          if (r < k && cc < k - 1) exp_win[r*KM+cc] = exp_win[r*KM+cc+1];
        end else begin
          exp_win[r*KM+cc] = (r < k && cc < k) ? 8'(base + 32'(r) * 32'(pitch) + 32'(cc)) : 8'h0;
        end
      end
      if (sh && r < k) exp_win[r*KM+k-1] = 8'(base + 32'(r) * 32'(pitch) + 32'(k - 1));
    end
    sel = dsel;
    check({tag, "_idle_before"}, 256'(o_busy), 256'(0));
    ksize = 3'(k); shift = sh; base_addr = base; row_pitch = pitch;
    if (dsel == 0) start = 1'b1; else start2 = 1'b1;
    done_cyc = -1; busy_ok = 1'b1; err_seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      tick();
      start = 1'b0; start2 = 1'b0;
      if (cyc == restart) begin
        if (dsel == 0) start = 1'b1; else start2 = 1'b1;
        ksize = 3'd5; base_addr = 32'h999; row_pitch = 16'h7;
      end
      if (cyc <= n) begin
        j  = cyc - 1;
        p  = j / nc;
        c  = sh ? k - 1 : j % nc;
        r1 = 2 * p + 1;
        e0 = base + 32'(2 * p) * 32'(pitch) + 32'(c);
        e1 = (r1 < k) ? base + 32'(r1) * 32'(pitch) + 32'(c) : 32'h0;
      end else begin
        e0 = 32'h0; e1 = 32'h0;
      end
      check({tag, "_addr"}, {o_a1, o_a0}, {e1, e0});
      if (!o_busy) busy_ok = 1'b0;
      if (o_err) err_seen = 1'b1;
      if (o_done) done_cyc = cyc;
    end
    check({tag, "_done_cycle"}, 256'(done_cyc), 256'(exp_done));
    check({tag, "_busy_span"}, 256'(busy_ok), 256'(1));
    check({tag, "_no_err"}, 256'(err_seen), 256'(0));
    check({tag, "_window"}, 256'(o_win), 256'(pack_exp()));
    tick();
    check({tag, "_done_pulse"}, {o_done, o_busy}, 256'(0));
    tick(); tick();
    check({tag, "_no_extra_done"}, 256'(o_done), 256'(0));
    check({tag, "_window_stable"}, 256'(o_win), 256'(pack_exp()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < KM * KM; i++) exp_win[i] = 8'h0;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; shift = 1'b0;
    ksize = 3'd0; base_addr = 32'h0; row_pitch = 16'h0;
    tick(); tick(); tick();
    check("reset_win", {win2[199:0], win1[199:0]} != '0, 256'(0));
    check("reset_flags", {done1, busy1, err1, done2, busy2, err2}, 256'(0));
    check("reset_addr", {a0_1, a1_1, a0_2, a1_2}, 256'(0));
    check("bram_const", {ben1, brst1, bdin1, bwen1}, {1'b1, 1'b0, 32'h0, 4'h0});
    rst = 1'b0;
    tick();

    run_load(0, 3, 1'b0, 32'h100, 16'h20, 8, 0, "full_k3");
    check("full_k3_e21", 256'(win1[(2*KM+1)*8 +: 8]), 256'(8'h41));
    run_load(0, 3, 1'b1, 32'h101, 16'h20, 4, 0, "shift_k3");
    check("shift_k3_e02", 256'(win1[(0*KM+2)*8 +: 8]), 256'(8'h03));
    check("shift_k3_e20", 256'(win1[(2*KM+0)*8 +: 8]), 256'(8'h41));
    run_load(0, 1, 1'b0, 32'h37, 16'h10, 3, 0, "full_k1");
    check("full_k1_win", 256'(win1), 256'(8'h37));
    run_load(0, 5, 1'b0, 32'h0FE, 16'h10, 17, 0, "full_k5");
    check("full_k5_e44", 256'(win1[(4*KM+4)*8 +: 8]), 256'(8'h42));
    check("full_k5_e00", 256'(win1[7:0]), 256'(8'hFE));

    for (int t = 0; t < 2; t++) begin
      ksize = (t == 0) ? 3'd0 : 3'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("reject_err", {err1, busy1}, {1'b1, 1'b0});
      check("reject_addr", {a0_1, a1_1}, 256'(0));
      tick();
      check("reject_pulse", {err1, busy1, done1}, 256'(0));
      check("reject_win_held", 256'(win1), 256'(pack_exp()));
    end

    run_load(0, 2, 1'b0, 32'h200, 16'h8, 4, 2, "busy_restart");

    ksize = 3'd3; shift = 1'b0; base_addr = 32'h300; row_pitch = 16'h20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", {win1 != '0, busy1, done1}, 256'(0));
    check("midrst_addr", {a0_1, a1_1}, 256'(0));
    tick();
    check("midrst_no_done", {done1, busy1}, 256'(0));
    for (int i = 0; i < KM * KM; i++) exp_win[i] = 8'h0;
    run_load(0, 3, 1'b0, 32'h300, 16'h20, 8, 0, "after_rst");

    run_load(1, 3, 1'b0, 32'h100, 16'h20, 9, 0, "lat2_k3");
    check("lat2_k3_e22", 256'(win2[(2*KM+2)*8 +: 8]), 256'(8'h42));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
